// File: rtl/snake_controller_if.sv
// Game-side signal bundle between the snake sequencer and its surroundings
// (input stimulus from buttons/timer, cell indices and status to the LED driver).
interface snake_controller_if;
  logic       start;
  logic       tick;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic [3:0] position;
  logic [3:0] apple;
  logic [3:0] score;
  logic       playing;
  logic       game_over;
  logic       win;

  modport master (
    output start, tick, btn_up, btn_down, btn_left, btn_right,
    input  position, apple, score, playing, game_over, win
  );

  modport slave (
    input  start, tick, btn_up, btn_down, btn_left, btn_right,
    output position, apple, score, playing, game_over, win
  );
endinterface

// File: rtl/snake_controller.sv
// Snake game sequencer for the 4x4 play field: moves the head on tick, detects walls and apples.
// States: IDLE wait start | PLAY move on tick | CHECK apple test | NEW_APPLE respawn | GAME_OVER/WIN hold
module snake_controller #(
  parameter int         MAX_SCORE   = 15,
  parameter logic [3:0] START_POS   = 4'd0,
  parameter logic [3:0] START_APPLE = 4'd15
) (
  input  logic               i_clock,
  input  logic               i_reset,
  snake_controller_if.slave  io_game
);

  typedef enum logic [2:0] {
    S_IDLE, S_PLAY, S_CHECK, S_NEW_APPLE, S_GAME_OVER, S_WIN
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT
  } dir_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_SCORE);

  state_t     r_state;
  dir_t       r_dir;
  logic [3:0] r_position;
  logic [3:0] r_apple;
  logic [3:0] r_score;
  logic [3:0] r_fc;

  state_t     w_state_nxt;
  dir_t       w_dir_nxt;
  dir_t       w_btn_dir;
  logic [3:0] w_position_nxt;
  logic [3:0] w_apple_nxt;
  logic [3:0] w_score_nxt;
  logic [3:0] w_score_inc;
  logic [3:0] w_target;
  logic [1:0] w_row;
  logic [1:0] w_col;
  logic       w_wall;
  logic       w_btn_any;
  logic       w_dir_open;

  assign w_row       = r_position[3:2];
  assign w_col       = r_position[1:0];
  assign w_score_inc = r_score + 4'd1;
  assign w_btn_any   = io_game.btn_up | io_game.btn_down | io_game.btn_left | io_game.btn_right;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_dir      <= DIR_RIGHT;
      r_position <= START_POS;
      r_apple    <= START_APPLE;
      r_score    <= 4'd0;
      r_fc       <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_dir      <= w_dir_nxt;
      r_position <= w_position_nxt;
      r_apple    <= w_apple_nxt;
      r_score    <= w_score_nxt;
      r_fc       <= r_fc + 4'd1;
    end
  end

  // Target cell and wall test from the direction registered before the tick.
  always_comb begin
    w_wall   = 1'b0;
    w_target = r_position;
    case (r_dir)
      DIR_UP: begin
        w_wall   = (w_row == 2'd0);
        w_target = {w_row - 2'd1, w_col};
      end
      DIR_DOWN: begin
        w_wall   = (w_row == 2'd3);
        w_target = {w_row + 2'd1, w_col};
      end
      DIR_LEFT: begin
        w_wall   = (w_col == 2'd0);
        w_target = {w_row, w_col - 2'd1};
      end
      default: begin
        w_wall   = (w_col == 2'd3);
        w_target = {w_row, w_col + 2'd1};
      end
    endcase
  end

  always_comb begin
    w_btn_dir = DIR_RIGHT;
    if (io_game.btn_up)        w_btn_dir = DIR_UP;
    else if (io_game.btn_down) w_btn_dir = DIR_DOWN;
    else if (io_game.btn_left) w_btn_dir = DIR_LEFT;
  end

  assign w_dir_open = (r_state == S_IDLE) || (r_state == S_PLAY) ||
                      (r_state == S_CHECK) || (r_state == S_NEW_APPLE);

  always_comb begin
    w_state_nxt    = r_state;
    w_dir_nxt      = r_dir;
    w_position_nxt = r_position;
    w_apple_nxt    = r_apple;
    w_score_nxt    = r_score;

    if (w_dir_open && w_btn_any) w_dir_nxt = w_btn_dir;

    case (r_state)
      S_IDLE: begin
        if (io_game.start) w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (io_game.tick) begin
          if (w_wall) begin
            w_state_nxt = S_GAME_OVER;
          end else begin
            w_position_nxt = w_target;
            w_state_nxt    = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (r_position == r_apple) begin
          w_score_nxt = w_score_inc;
          w_state_nxt = (w_score_inc == LP_MAX) ? S_WIN : S_NEW_APPLE;
        end else begin
          w_state_nxt = S_PLAY;
        end
      end
      S_NEW_APPLE: begin
        w_apple_nxt = (r_fc != r_position) ? r_fc : r_fc + 4'd1;
        w_state_nxt = S_PLAY;
      end
      S_GAME_OVER, S_WIN: begin
        if (io_game.start) begin
          w_position_nxt = START_POS;
          w_apple_nxt    = START_APPLE;
          w_score_nxt    = 4'd0;
          w_dir_nxt      = DIR_RIGHT;
          w_state_nxt    = S_PLAY;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign io_game.position  = r_position;
  assign io_game.apple     = r_apple;
  assign io_game.score     = r_score;
  assign io_game.playing   = (r_state == S_PLAY) || (r_state == S_CHECK) || (r_state == S_NEW_APPLE);
  assign io_game.game_over = (r_state == S_GAME_OVER);
  assign io_game.win       = (r_state == S_WIN);

endmodule
